m24_bus_arbiter: RTL
====================

Name: m24_bus_arbiter

Overview:
Owns the single M24C08 I2C bus and shares it between two engines: the boot-time EEPROM reader (requester 0) and the EEPROM writer (requester 1).
It grants the bus to one engine at a time, muxes that engine's SCL/SDA/drive-enable onto the pins, and enforces bus-free time and the EEPROM internal write-cycle hold-off.
A watchdog revokes grants that are held too long.
It replaces the wired-AND merge of the two engines' outputs.

Parameters:
TBUF_TICKS, 4, tick count of idle bus between any grant release and the next grant (min 1).
TWR_TICKS, 1700, tick count of hold-off after a writer grant ends (≥5 ms at a 3 µs tick).
TIMEOUT_TICKS, 4096, maximum tick count a grant may be held before forced revoke.
CNT_W, 13, width of the shared tick counter; must hold the maximum of the three tick parameters.

Ports:
SYSCLK_IN  in  1  system clock
RESET_N_IN  in  1  asynchronous active-low reset
INT400K_IN  in  1  one-SYSCLK tick strobe from the shared prescaler
RD_REQ_IN  in  1  reader bus request, level; held for the whole transaction, dropped after its STOP
RD_GNT_OUT  out  1  reader grant
RD_SCL_IN  in  1  reader SCL
RD_SDA_IN  in  1  reader SDA
RD_SDAT_IN  in  1  reader SDA drive enable
WR_REQ_IN  in  1  writer bus request, same rules as RD_REQ_IN
WR_GNT_OUT  out  1  writer grant
WR_SCL_IN  in  1  writer SCL
WR_SDA_IN  in  1  writer SDA
WR_SDAT_IN  in  1  writer SDA drive enable
M24C08_SCL_OUT  out  1  bus SCL
M24C08_SDA_OUT  out  1  bus SDA
M24C08_SDAT_OUT  out  1  bus SDA drive enable (1 = drive)
BUSY_OUT  out  1  high whenever state ≠ IDLE
TIMEOUT_OUT  out  1  one-cycle pulse on watchdog revoke

Behaviour:
- Reset values, all outputs registered: GNTs 0, SCL 1, SDA 1, SDAT 0, BUSY 0, TIMEOUT 0; state IDLE; counter 0; stale flags 0.
- States and transitions:
  - IDLE: if an eligible request is present, go to GNT_RD or GNT_WR. If both are eligible in the same cycle, the reader wins (fixed priority).
  - GNT_RD / GNT_WR:
    - The GNT output rises in the cycle after state entry.
    - While granted, the bus outputs equal the granted engine's SCL/SDA/SDAT, registered, so 1 cycle latency.
    - On REQ low: GNT drops next cycle, bus goes to idle levels (SCL 1, SDA 1, SDAT 0). From GNT_RD go to BUF; from GNT_WR go to TWR.
  - BUF: count TBUF_TICKS ticks, then go to IDLE.
  - TWR: count TWR_TICKS ticks, then go to BUF. All requests, including the reader's, wait.
- Eligibility: a requester is eligible only if its REQ is high and its stale flag is clear.
- Watchdog:
  - The counter clears on grant entry and increments on each tick while granted.
  - When it reaches TIMEOUT_TICKS: GNT drops, TIMEOUT_OUT pulses one cycle, and the revoked requester's stale flag is set.
  - Next state is RECOVER if the optional feature is compiled in, else BUF. For a writer revoke, the path passes through TWR before BUF.
  - The stale flag clears in the cycle REQ is seen low. A requester that never drops REQ is never re-granted.
- Counter: saturates and never wraps. A tick arriving in the same cycle as a state change is not counted in the new state.
- Tick stride:
  - Ticks are counted only on INT400K_IN.
  - INT400K_IN held high continuously counts every cycle; legal, bench use only.
- REQ re-asserted during BUF/TWR: honoured only after returning to IDLE. A REQ pulse that rises and falls entirely during BUF/TWR is lost.
- Asynchronous reset mid-grant: outputs go immediately to reset values; no STOP is generated.

Optional Feature:
M24_BUS_RECOVERY_EN:
- Defined: RECOVER state generates I2C bus recovery, one bus step per tick:
  - 9 SCL low/high pulses with SDA released (18 ticks),
  - then a STOP: SCL low with SDA driven low, SCL high, SDA released high (3 ticks),
  - then BUF.
  - BUSY stays high throughout; both GNTs stay low.
- Undefined: RECOVER does not exist; timeout goes directly to BUF (or TWR for a writer revoke), and the recovery sub-module is not instantiated.

Decomposition:
- Shared definitions file m24_bus_defs: state encodings (IDLE, GNT_RD, GNT_WR, BUF, TWR, RECOVER), requester IDs (RD = 0, WR = 1), default tick constants.
- One natural sub-module, m24_bus_recovery: tick-driven 9-pulse-plus-STOP sequencer with a start/done handshake. Instantiated only under M24_BUS_RECOVERY_EN.

Test Plan:
- RD_REQ and WR_REQ rise in the same cycle from IDLE → RD_GNT high 1 cycle later and WR_GNT stays 0. RD_REQ drops → BUF for 4 ticks, then WR_GNT rises.
- Writer grant with WR_SCL toggling → M24C08_SCL_OUT follows with 1-cycle lag. WR_REQ drops → no grant for 1700 + 4 ticks even with RD_REQ high, then RD_GNT.
- RD_REQ held for 4096 ticks → TIMEOUT_OUT one-cycle pulse and RD_GNT low. With RD_REQ still high, no re-grant for 10000 ticks; after RD_REQ low then high → granted after BUF.
- With M24_BUS_RECOVERY_EN, the previous case → exactly 9 SCL high pulses on M24C08_SCL_OUT, then SDA rises while SCL is high (STOP), then BUF.
- RESET_N_IN low mid writer grant → SCL 1, SDA 1, SDAT 0, GNTs 0 asynchronously. After release, state IDLE and RD_REQ granted with no TWR wait.

Source files
------------

// File: rtl/m24_bus_defs.sv
// Shared definitions for the M24C08 bus arbiter: state encodings, requester IDs,
// default tick constants and the bus-recovery step decoder.
package m24_bus_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GNT_RD  = 3'd1,
        ST_GNT_WR  = 3'd2,
        ST_BUF     = 3'd3,
        ST_TWR     = 3'd4,
        ST_RECOVER = 3'd5
    } arb_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_e;

    typedef struct packed {
        logic scl;
        logic sda;
        logic sdat;
    } bus_t;

    localparam bus_t BUS_IDLE = '{scl: 1'b1, sda: 1'b1, sdat: 1'b0};

    localparam int TBUF_TICKS_DEF    = 4;
    localparam int TWR_TICKS_DEF     = 1700;
    localparam int TIMEOUT_TICKS_DEF = 4096;
    localparam int CNT_W_DEF         = 13;

    // Steps 0..17 are nine low/high SCL pulses, 18..20 form the STOP.
    localparam logic [4:0] REC_LAST_STEP = 5'd20;

    function automatic bus_t rec_step_bus(input logic [4:0] step);
        bus_t b;
        b = BUS_IDLE;
        if (step < 5'd18) begin
            b.scl = step[0];
        end else if (step == 5'd18) begin
            b = '{scl: 1'b0, sda: 1'b0, sdat: 1'b1};
        end else if (step == 5'd19) begin
            b = '{scl: 1'b1, sda: 1'b0, sdat: 1'b1};
        end else begin
            b = BUS_IDLE;
        end
        return b;
    endfunction

endpackage

// File: rtl/m24_bus_recovery.sv
// Tick-driven I2C bus recovery sequencer: nine SCL pulses with SDA released,
// then a STOP; start pulse in, one-cycle done pulse out.
module m24_bus_recovery
    import m24_bus_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       start_i,
    output bus_t       bus_o,
    output logic       done_o
);

    logic       active_q, active_d;
    logic [4:0] step_q, step_d;

    // Step sequencing and done detection
    always_comb begin
        active_d = active_q;
        step_d   = step_q;
        done_o   = 1'b0;
        if (start_i) begin
            active_d = 1'b1;
            step_d   = 5'd0;
        end else if (active_q && tick_i) begin
            if (step_q == REC_LAST_STEP) begin
                active_d = 1'b0;
                step_d   = 5'd0;
                done_o   = 1'b1;
            end else begin
                step_d = step_q + 5'd1;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Bus levels for the current step; idle when not sequencing
    always_comb begin
        if (active_q) begin
            bus_o = rec_step_bus(step_q);
        end else begin
            bus_o = BUS_IDLE;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            step_q   <= 5'd0;
        end else begin
            active_q <= active_d;
            step_q   <= step_d;
        end
    end

endmodule

// File: rtl/m24_bus_arbiter.sv
// Two-requester arbiter for the M24C08 I2C bus with bus-free time, write-cycle
// hold-off and grant watchdog. Define M24_BUS_RECOVERY_EN to add bus recovery after a revoke.
module m24_bus_arbiter
    import m24_bus_defs::*;
#(
    parameter int TBUF_TICKS    = TBUF_TICKS_DEF,
    parameter int TWR_TICKS     = TWR_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic SYSCLK_IN,
    input  logic RESET_N_IN,
    input  logic INT400K_IN,
    input  logic RD_REQ_IN,
    output logic RD_GNT_OUT,
    input  logic RD_SCL_IN,
    input  logic RD_SDA_IN,
    input  logic RD_SDAT_IN,
    input  logic WR_REQ_IN,
    output logic WR_GNT_OUT,
    input  logic WR_SCL_IN,
    input  logic WR_SDA_IN,
    input  logic WR_SDAT_IN,
    output logic M24C08_SCL_OUT,
    output logic M24C08_SDA_OUT,
    output logic M24C08_SDAT_OUT,
    output logic BUSY_OUT,
    output logic TIMEOUT_OUT
);

    localparam logic [CNT_W-1:0] TBUF_C    = CNT_W'(TBUF_TICKS);
    localparam logic [CNT_W-1:0] TWR_C     = CNT_W'(TWR_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_gnt_q, rd_gnt_d;
    logic             wr_gnt_q, wr_gnt_d;
    bus_t             bus_q, bus_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             rd_stale_q, rd_stale_d;
    logic             wr_stale_q, wr_stale_d;
    logic             revoke_s;
    req_id_e          rev_id_s;

`ifdef M24_BUS_RECOVERY_EN
    req_id_e rev_id_q, rev_id_d;
    logic    rec_start_s;
    logic    rec_done_s;
    bus_t    rec_bus_s;

    m24_bus_recovery u_recovery (
        .clk     (SYSCLK_IN),
        .rst_n   (RESET_N_IN),
        .tick_i  (INT400K_IN),
        .start_i (rec_start_s),
        .bus_o   (rec_bus_s),
        .done_o  (rec_done_s)
    );
`endif

    // Next-state, grant, bus mux, watchdog and stale-flag logic
    always_comb begin
        state_d    = state_q;
        bus_d      = BUS_IDLE;
        rd_gnt_d   = 1'b0;
        wr_gnt_d   = 1'b0;
        timeout_d  = 1'b0;
        revoke_s   = 1'b0;
        rev_id_s   = REQ_RD;
        rd_stale_d = RD_REQ_IN ? rd_stale_q : 1'b0;
        wr_stale_d = WR_REQ_IN ? wr_stale_q : 1'b0;
`ifdef M24_BUS_RECOVERY_EN
        rev_id_d    = rev_id_q;
        rec_start_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (RD_REQ_IN && !rd_stale_q) begin
                    state_d = ST_GNT_RD;
                end else if (WR_REQ_IN && !wr_stale_q) begin
                    state_d = ST_GNT_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_RD: begin
                if (!RD_REQ_IN) begin
                    state_d = ST_BUF;
                end else if (cnt_q >= TIMEOUT_C) begin
                    revoke_s = 1'b1;
                    rev_id_s = REQ_RD;
                end else begin
                    rd_gnt_d = 1'b1;
                    bus_d    = '{scl: RD_SCL_IN, sda: RD_SDA_IN, sdat: RD_SDAT_IN};
                end
            end
            ST_GNT_WR: begin
                if (!WR_REQ_IN) begin
                    state_d = ST_TWR;
                end else if (cnt_q >= TIMEOUT_C) begin
                    revoke_s = 1'b1;
                    rev_id_s = REQ_WR;
                end else begin
                    wr_gnt_d = 1'b1;
                    bus_d    = '{scl: WR_SCL_IN, sda: WR_SDA_IN, sdat: WR_SDAT_IN};
                end
            end
            ST_BUF: begin
                if (cnt_q >= TBUF_C) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUF;
                end
            end
            ST_TWR: begin
                if (cnt_q >= TWR_C) begin
                    state_d = ST_BUF;
                end else begin
                    state_d = ST_TWR;
                end
            end
`ifdef M24_BUS_RECOVERY_EN
            ST_RECOVER: begin
                bus_d = rec_bus_s;
                if (rec_done_s) begin
                    state_d = (rev_id_q == REQ_WR) ? ST_TWR : ST_BUF;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A writer revoke still owes the EEPROM its write-cycle hold-off
        if (revoke_s) begin
            timeout_d = 1'b1;
            if (rev_id_s == REQ_WR) begin
                wr_stale_d = 1'b1;
            end else begin
                rd_stale_d = 1'b1;
            end
`ifdef M24_BUS_RECOVERY_EN
            state_d     = ST_RECOVER;
            rec_start_s = 1'b1;
            rev_id_d    = rev_id_s;
`else
            state_d = (rev_id_s == REQ_WR) ? ST_TWR : ST_BUF;
`endif
        end else begin
            timeout_d = 1'b0;
        end

        // Counter restarts on every state change; ticks saturate instead of wrapping
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (INT400K_IN && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            bus_q      <= BUS_IDLE;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rd_stale_q <= 1'b0;
            wr_stale_q <= 1'b0;
`ifdef M24_BUS_RECOVERY_EN
            rev_id_q   <= REQ_RD;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            bus_q      <= bus_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            rd_stale_q <= rd_stale_d;
            wr_stale_q <= wr_stale_d;
`ifdef M24_BUS_RECOVERY_EN
            rev_id_q   <= rev_id_d;
`endif
        end
    end

    assign RD_GNT_OUT      = rd_gnt_q;
    assign WR_GNT_OUT      = wr_gnt_q;
    assign M24C08_SCL_OUT  = bus_q.scl;
    assign M24C08_SDA_OUT  = bus_q.sda;
    assign M24C08_SDAT_OUT = bus_q.sdat;
    assign BUSY_OUT        = busy_q;
    assign TIMEOUT_OUT     = timeout_q;

endmodule
